// File: rtl/vx_issue_scheduler_pkg.sv
// Shared constants for the issue scheduler: starvation default, counter widths
// and the index-width helper used by the top and the picker.
package vx_issue_scheduler_pkg;

  localparam int STARVE_LIMIT_DEFAULT = 15;
  localparam int STARVE_CNT_W         = 8;
  localparam int PERF_CTR_BITS        = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_issue_scheduler_starve_rr_pick.sv
// Combinational picker: lowest-index starved requester wins, otherwise the
// first eligible requester at or after rr_ptr (wrapping).
module vx_issue_scheduler_starve_rr_pick
  import vx_issue_scheduler_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int IDXW     = idx_w(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] eligible,
  input  logic [NUM_REQS-1:0] starved,
  input  logic [IDXW-1:0]     rr_ptr,
  output logic                pick_valid,
  output logic [IDXW-1:0]     pick_idx
);

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    // Descending scans so the last hit is the lowest index / nearest to rr_ptr.
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (starved[i]) begin
        pick_valid = 1'b1;
        pick_idx   = IDXW'(i);
      end
    end
    if (!pick_valid) begin
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
        if (eligible[(int'(rr_ptr) + k) % NUM_REQS]) begin
          pick_valid = 1'b1;
          pick_idx   = IDXW'((int'(rr_ptr) + k) % NUM_REQS);
        end
      end
    end
  end

endmodule

// File: rtl/vx_issue_scheduler.sv
// Issue scheduler: NUM_REQS warps share one registered issue slot, arbitrated
// round-robin with a starvation override; counts stall cycles.
module vx_issue_scheduler
  import vx_issue_scheduler_pkg::*;
#(
  parameter int NUM_REQS     = 4,
  parameter int DATAW        = 64,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS-1:0]       req_ops_ready,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  output logic [idx_w(NUM_REQS)-1:0] out_idx,
  input  logic                      out_ready,
  output logic [PERF_CTR_BITS-1:0]  perf_stalls
);

  localparam int IDXW = idx_w(NUM_REQS);
  localparam int SCW  = STARVE_CNT_W;

  logic [NUM_REQS-1:0]      eligible;
  logic [NUM_REQS-1:0]      starved;
  logic [NUM_REQS-1:0]      grant;
  logic                     can_load;
  logic                     pick_valid;
  logic                     grant_fire;
  logic [IDXW-1:0]          pick_idx;
  logic [DATAW-1:0]         data_arr [NUM_REQS];

  logic [IDXW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [SCW-1:0]           starve_cnt_q [NUM_REQS];
  logic [SCW-1:0]           starve_cnt_d [NUM_REQS];
  logic                     out_valid_q, out_valid_d;
  logic [DATAW-1:0]         out_data_q, out_data_d;
  logic [IDXW-1:0]          out_idx_q, out_idx_d;
  logic [PERF_CTR_BITS-1:0] perf_stalls_q, perf_stalls_d;

  assign eligible = req_valid & req_ops_ready;
  assign can_load = ~out_valid_q | out_ready;

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_req
    assign data_arr[gi] = req_data[gi*DATAW +: DATAW];
    assign starved[gi]  = eligible[gi] && (starve_cnt_q[gi] == SCW'(STARVE_LIMIT));
  end

  vx_issue_scheduler_starve_rr_pick #(
    .NUM_REQS (NUM_REQS),
    .IDXW     (IDXW)
  ) u_pick (
    .eligible   (eligible),
    .starved    (starved),
    .rr_ptr     (rr_ptr_q),
    .pick_valid (pick_valid),
    .pick_idx   (pick_idx)
  );

  // No grant while reset is held so req_ready reads zero during reset.
  assign grant_fire = can_load & pick_valid & ~reset;

  always_comb begin
    grant = '0;
    if (grant_fire) grant[pick_idx] = 1'b1;
  end

  assign req_ready = grant;

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_idx_d     = out_idx_q;
    perf_stalls_d = perf_stalls_q;
    if (grant_fire) begin
      rr_ptr_d    = (pick_idx == IDXW'(NUM_REQS - 1)) ? '0 : pick_idx + 1'b1;
      out_valid_d = 1'b1;
      out_data_d  = data_arr[pick_idx];
      out_idx_d   = pick_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if ((|req_valid) && !(|grant)) perf_stalls_d = perf_stalls_q + 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      starve_cnt_d[i] = starve_cnt_q[i];
      if (!req_valid[i] || grant[i]) begin
        starve_cnt_d[i] = '0;
      end else if (starve_cnt_q[i] != SCW'(STARVE_LIMIT)) begin
        starve_cnt_d[i] = starve_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q      <= '0;
      out_valid_q   <= 1'b0;
      out_idx_q     <= '0;
      perf_stalls_q <= '0;
      for (int i = 0; i < NUM_REQS; i++) starve_cnt_q[i] <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      out_valid_q   <= out_valid_d;
      out_idx_q     <= out_idx_d;
      perf_stalls_q <= perf_stalls_d;
      for (int i = 0; i < NUM_REQS; i++) starve_cnt_q[i] <= starve_cnt_d[i];
    end
  end

  // Payload needs no reset; it is only observed while out_valid is set.
  always_ff @(posedge clk) begin
    out_data_q <= out_data_d;
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_idx     = out_idx_q;
  assign perf_stalls = perf_stalls_q;

endmodule

// File: doc/vx_issue_scheduler.md
VX_ISSUE_SCHEDULER -- requirements
Module: VX_issue_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of warp requesters sharing one issue slot (ISSUE_RATIO), range 1..32.
REQ-002 SHALL have parameter DATAW, default 64, payload width per requester.
REQ-003 SHALL have parameter STARVE_LIMIT, default 15, stall cycles after which a requester gains forced priority, range 1..255.
REQ-004 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_REQS  per-warp instruction pending.
REQ-007 SHALL have port req_ops_ready  input  NUM_REQS  per-warp scoreboard operands not busy.
REQ-008 SHALL have port req_data  input  NUM_REQS*DATAW  per-warp payload.
REQ-009 SHALL have port req_ready  output  NUM_REQS  one-hot grant; accept when req_valid[i] & req_ready[i].
REQ-010 SHALL have port out_valid  output  1  registered issue valid.
REQ-011 SHALL have port out_data  output  DATAW  registered payload of granted warp.
REQ-012 SHALL have port out_idx  output  CLOG2(NUM_REQS) (min 1)  index of granted warp.
REQ-013 SHALL have port out_ready  input  1  downstream accept.
REQ-014 SHALL have port perf_stalls  output  PERF_CTR_BITS  cycles with any req_valid high and no grant.

Function
REQ-015 SHALL treat requester i as eligible when req_valid[i] & req_ops_ready[i].
REQ-016 SHALL compute can_load = ~out_valid | out_ready and assert at most one req_ready bit, only when can_load.
REQ-017 SHALL grant, if any eligible requester has starve_cnt == STARVE_LIMIT, the lowest-index such requester.
REQ-018 SHALL otherwise grant round-robin: first eligible index at or after rr_ptr, wrapping from NUM_REQS-1 to 0.
REQ-019 SHALL set rr_ptr to (granted index + 1) mod NUM_REQS on each grant; SHALL leave it unchanged otherwise.
REQ-020 SHALL load out_data/out_idx and set out_valid the cycle after a grant (latency 1).
REQ-021 SHALL clear out_valid when out_ready and no grant; SHALL allow grant and drain in the same cycle (full throughput, one issue per cycle).
REQ-022 SHALL hold out_valid, out_data and out_idx stable while out_valid & ~out_ready.
REQ-023 SHALL increment starve_cnt[i], saturating at STARVE_LIMIT, when req_valid[i] and not granted; SHALL clear it on grant or when req_valid[i] is low.
REQ-024 SHALL count stalls when the requester is blocked by req_ops_ready (req_valid high, not eligible) toward starve_cnt but never grant a non-eligible requester.
REQ-025 SHALL increment perf_stalls (wrapping) each cycle |req_valid & ~|req_ready.
REQ-026 SHALL with NUM_REQS=1 degenerate to a 1-entry pipe register with out_idx = 0.

Reset
REQ-027 SHALL on reset set out_valid=0, out_idx=0, rr_ptr=0, all starve_cnt=0, perf_stalls=0, req_ready=0; out_data undefined.
REQ-028 SHALL discard a held output entry when reset asserts mid-operation; first grant after reset goes to lowest eligible index.

Structure
REQ-029 SHALL keep STARVE_LIMIT default and index-width helper localparams in VX_gpu_pkg; no new typedefs.
REQ-030 SHALL isolate the starve-override + round-robin picker combinational logic in one sub-module VX_starve_rr_pick.

Verification
REQ-031 SHALL verify: all 4 eligible, out_ready=1 for 8 cycles -> out_idx sequence 0,1,2,3,0,1,2,3.
REQ-032 SHALL verify: only req 2 eligible, out_ready=1 -> req_ready=4'b0100 each cycle, out_idx=2 one cycle later, perf_stalls unchanged.
REQ-033 SHALL verify: out_ready=0 for 5 cycles with entry held -> out_data/out_idx unchanged, req_ready=0, perf_stalls +5.
REQ-034 SHALL verify: STARVE_LIMIT=3, req 3 valid with ops_ready=0 for 3 cycles then 1, reqs 0-2 eligible -> next grant is req 3 regardless of rr_ptr.
REQ-035 SHALL verify: reset asserted while out_valid=1 & out_ready=0 -> next cycle out_valid=0, rr_ptr=0, counters zero.
REQ-036 SHALL verify: rr_ptr=3, eligible {0,3} -> grants 3 then 0 (wrap-around).
